// File: rtl/instr_encoder32.sv
// Minisys instruction encoder: packs symbolic requests into 32-bit words and streams them into IMEM.
// Optional macro ENC_SHIFT_EN makes SLL/SRL/SRA encodable; otherwise they take the illegal path.
module instr_encoder32 #(
  parameter int ADDR_WIDTH = 14,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [4:0]            req_rs,
  input  logic [4:0]            req_rt,
  input  logic [4:0]            req_rd,
  input  logic [25:0]           req_imm,
  output logic                  imem_we,
  input  logic                  imem_ready,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  err_illegal
);

  typedef enum logic [1:0] {EMPTY, PEND, FULL} state_t;

  localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;
  localparam logic [ADDR_WIDTH-1:0] AddrOne  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CountOne = (ADDR_WIDTH + 1)'(1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic                    err_q, err_d;

  logic [31:0] encWord;
  logic        encLegal;
  logic        transfer;
  logic        wrDone;
  logic        lastDone;

  // Field packing; fields an op does not use are never routed into its word.
  always_comb begin
    encWord  = '0;
    encLegal = 1'b1;
    case (req_op)
      4'd0:  encWord = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h20};
      4'd1:  encWord = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h22};
      4'd2:  encWord = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h24};
      4'd3:  encWord = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h25};
      4'd4:  encWord = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h2A};
      4'd5:  encWord = {6'h00, req_rs, 15'd0, 6'h08};
      4'd6:  encWord = {6'h08, req_rs, req_rt, req_imm[15:0]};
      4'd7:  encWord = {6'h23, req_rs, req_rt, req_imm[15:0]};
      4'd8:  encWord = {6'h2B, req_rs, req_rt, req_imm[15:0]};
      4'd9:  encWord = {6'h04, req_rs, req_rt, req_imm[15:0]};
      4'd10: encWord = {6'h05, req_rs, req_rt, req_imm[15:0]};
      4'd11: encWord = {6'h02, req_imm};
      4'd12: encWord = {6'h03, req_imm};
`ifdef ENC_SHIFT_EN
      4'd13: encWord = {6'h00, 5'd0, req_rt, req_rd, req_imm[4:0], 6'h00};
      4'd14: encWord = {6'h00, 5'd0, req_rt, req_rd, req_imm[4:0], 6'h02};
      4'd15: encWord = {6'h00, 5'd0, req_rt, req_rd, req_imm[4:0], 6'h03};
`endif
      default: encLegal = 1'b0;
    endcase
  end

  assign imem_we     = (state_q == PEND);
  assign full        = (state_q == FULL);
  assign req_ready   = !clear && (state_q != FULL) && ((state_q == EMPTY) || imem_ready);
  assign transfer    = req_valid && req_ready;
  assign wrDone      = imem_we && imem_ready;
  assign lastDone    = wrDone && (addr_q == LastAddr);
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign count       = count_q;
  assign err_illegal = err_q;

  // A word accepted alongside the final write has nowhere to go and is dropped.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = transfer && !encLegal;
    if (clear) begin
      state_d = EMPTY;
      addr_d  = BaseAddr;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      if (wrDone) begin
        count_d = count_q + CountOne;
        if (lastDone) begin
          state_d = FULL;
        end else begin
          addr_d  = addr_q + AddrOne;
          state_d = EMPTY;
        end
      end
      if (transfer && encLegal && !lastDone) begin
        state_d = PEND;
        wdata_d = encWord;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      addr_q  <= BaseAddr;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder32.sv
// Self-checking bench for instr_encoder32: fixed encoding vectors, handshake corner sequences,
// and randomized traffic against a behavioural model.
module tb_instr_encoder32;

  localparam int AW  = 14;
  localparam int SAW = 2;

`ifdef ENC_SHIFT_EN
  localparam bit ShiftEn = 1'b1;
`else
  localparam bit ShiftEn = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic clear, reqValid, imemReady;
  logic [3:0]  reqOp;
  logic [4:0]  reqRs, reqRt, reqRd;
  logic [25:0] reqImm;
  logic reqReady, imemWe, full, errIllegal;
  logic [AW-1:0] imemAddr;
  logic [31:0]   imemWdata;
  logic [AW:0]   count;

  logic clearS, reqValidS, imemReadyS, reqReadyS, imemWeS, fullS, errIllegalS;
  logic [SAW-1:0] imemAddrS;
  logic [31:0]    imemWdataS;
  logic [SAW:0]   countS;

  instr_encoder32 #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .req_valid(reqValid), .req_ready(reqReady),
    .req_op(reqOp), .req_rs(reqRs), .req_rt(reqRt), .req_rd(reqRd), .req_imm(reqImm),
    .imem_we(imemWe), .imem_ready(imemReady), .imem_addr(imemAddr), .imem_wdata(imemWdata),
    .count(count), .full(full), .err_illegal(errIllegal)
  );

  instr_encoder32 #(.ADDR_WIDTH(SAW), .BASE_ADDR(0)) dutSmall (
    .clock(clock), .reset(reset), .clear(clearS),
    .req_valid(reqValidS), .req_ready(reqReadyS),
    .req_op(reqOp), .req_rs(reqRs), .req_rt(reqRt), .req_rd(reqRd), .req_imm(reqImm),
    .imem_we(imemWeS), .imem_ready(imemReadyS), .imem_addr(imemAddrS), .imem_wdata(imemWdataS),
    .count(countS), .full(fullS), .err_illegal(errIllegalS)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [25:0] imm;
    logic [31:0] word;
    bit          legal;
  } vec_t;

  vec_t vecs[17];

  int compared   = 0;
  int mismatched = 0;
  int expAddr    = 0;

  bit          mPend, mFull, mErr, expReady, xfer, done, legal;
  int          mAddr, mCount;
  logic [31:0] mWord, word;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] op, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd, input logic [25:0] imm);
    reqValid = valid;
    reqOp    = op;
    reqRs    = rs;
    reqRt    = rt;
    reqRd    = rd;
    reqImm   = imm;
  endtask

  // Reference encoder built from the instruction-format rules with plain arithmetic.
  function automatic void refEncode(input int op, input int rs, input int rt, input int rd,
                                    input int imm, output bit ok, output logic [31:0] w);
    longint v;
    int     f;
    ok = 1'b1;
    v  = 0;
    if (op <= 4) begin
      f = (op == 0) ? 32 : (op == 1) ? 34 : (op == 2) ? 36 : (op == 3) ? 37 : 42;
      v = (longint'(rs) << 21) + (longint'(rt) << 16) + (longint'(rd) << 11) + f;
    end else if (op == 5) begin
      v = (longint'(rs) << 21) + 8;
    end else if (op <= 10) begin
      f = (op == 6) ? 8 : (op == 7) ? 35 : (op == 8) ? 43 : (op == 9) ? 4 : 5;
      v = (longint'(f) << 26) + (longint'(rs) << 21) + (longint'(rt) << 16) + (imm % 65536);
    end else if (op <= 12) begin
      v = (longint'(op - 9) << 26) + imm;
    end else begin
      ok = ShiftEn;
      f  = (op == 13) ? 0 : (op == 14) ? 2 : 3;
      v  = (longint'(rt) << 16) + (longint'(rd) << 11) + (longint'(imm % 32) << 6) + f;
    end
    w = ok ? 32'(v) : 32'h0;
  endfunction

  initial begin
    vecs[0]  = '{4'd0,  5'd1,  5'd2,  5'd3,  26'd0,        32'h00221820, 1'b1};
    vecs[1]  = '{4'd6,  5'd0,  5'd1,  5'd0,  26'd5,        32'h20010005, 1'b1};
    vecs[2]  = '{4'd7,  5'd1,  5'd2,  5'd0,  26'd4,        32'h8C220004, 1'b1};
    vecs[3]  = '{4'd5,  5'd31, 5'd7,  5'd9,  26'h3FFFFFF,  32'h03E00008, 1'b1};
    vecs[4]  = '{4'd11, 5'd0,  5'd0,  5'd0,  26'h10,       32'h08000010, 1'b1};
    vecs[5]  = '{4'd1,  5'd4,  5'd5,  5'd6,  26'h3FFFFFF,  32'h00853022, 1'b1};
    vecs[6]  = '{4'd2,  5'd7,  5'd8,  5'd9,  26'h155,      32'h00E84824, 1'b1};
    vecs[7]  = '{4'd3,  5'd31, 5'd31, 5'd31, 26'd0,        32'h03FFF825, 1'b1};
    vecs[8]  = '{4'd4,  5'd10, 5'd11, 5'd12, 26'd0,        32'h014B602A, 1'b1};
    vecs[9]  = '{4'd8,  5'd29, 5'd31, 5'd5,  26'h3FFFFFC,  32'hAFBFFFFC, 1'b1};
    vecs[10] = '{4'd9,  5'd1,  5'd2,  5'd0,  26'h8000,     32'h10228000, 1'b1};
    vecs[11] = '{4'd10, 5'd3,  5'd0,  5'd0,  26'hFFFF,     32'h1460FFFF, 1'b1};
    vecs[12] = '{4'd12, 5'd5,  5'd0,  5'd0,  26'h3FFFFFF,  32'h0FFFFFFF, 1'b1};
    vecs[13] = '{4'd13, 5'd9,  5'd1,  5'd2,  26'd4,        32'h00011100, ShiftEn};
    vecs[14] = '{4'd14, 5'd0,  5'd3,  5'd4,  26'hFF,       32'h000327C2, ShiftEn};
    vecs[15] = '{4'd15, 5'd0,  5'd31, 5'd31, 26'd1,        32'h001FF843, ShiftEn};
    vecs[16] = '{4'd6,  5'd31, 5'd31, 5'd0,  26'hFFFF,     32'h23FFFFFF, 1'b1};

    clear = 1'b0; imemReady = 1'b1;
    clearS = 1'b0; reqValidS = 1'b0; imemReadyS = 1'b1;
    applyStimulus(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 26'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("rst_we",    64'(imemWe),     64'(0));
    checkOutput("rst_addr",  64'(imemAddr),   64'(0));
    checkOutput("rst_wdata", 64'(imemWdata),  64'(0));
    checkOutput("rst_count", 64'(count),      64'(0));
    checkOutput("rst_full",  64'(full),       64'(0));
    checkOutput("rst_err",   64'(errIllegal), 64'(0));
    checkOutput("rst_ready", 64'(reqReady),   64'(1));

    // Table vectors streamed back-to-back with IMEM always ready.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm);
      #1 checkOutput("tbl_ready", 64'(reqReady), 64'(1));
      @(negedge clock);
      reqValid = 1'b0;
      checkOutput("tbl_count", 64'(count), 64'(expAddr));
      checkOutput("tbl_addr",  64'(imemAddr), 64'(expAddr));
      if (vecs[i].legal) begin
        checkOutput("tbl_we",    64'(imemWe),     64'(1));
        checkOutput("tbl_wdata", 64'(imemWdata),  64'(vecs[i].word));
        checkOutput("tbl_err",   64'(errIllegal), 64'(0));
        expAddr++;
      end else begin
        checkOutput("ill_we",  64'(imemWe),     64'(0));
        checkOutput("ill_err", 64'(errIllegal), 64'(1));
      end
    end
    @(negedge clock);
    checkOutput("tbl_end_we",    64'(imemWe),     64'(0));
    checkOutput("tbl_end_count", 64'(count),      64'(expAddr));
    checkOutput("tbl_end_err",   64'(errIllegal), 64'(0));

    // IMEM back-pressure for three cycles while a word is pending.
    applyStimulus(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 26'h3FFFFFF);
    @(negedge clock);
    reqValid  = 1'b0;
    imemReady = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput("stall_ready", 64'(reqReady),  64'(0));
      checkOutput("stall_we",    64'(imemWe),    64'(1));
      checkOutput("stall_addr",  64'(imemAddr),  64'(expAddr));
      checkOutput("stall_wdata", 64'(imemWdata), 64'h00221820);
      checkOutput("stall_count", 64'(count),     64'(expAddr));
      if (k < 3) @(negedge clock);
    end
    imemReady = 1'b1;
    #1 checkOutput("stall_release_ready", 64'(reqReady), 64'(1));
    @(negedge clock);
    checkOutput("stall_done_we",    64'(imemWe),   64'(0));
    checkOutput("stall_done_count", 64'(count),    64'(expAddr + 1));
    checkOutput("stall_done_addr",  64'(imemAddr), 64'(expAddr + 1));
    @(negedge clock);
    checkOutput("stall_once_count", 64'(count), 64'(expAddr + 1));

    // Clear collides with a new request and a completing write.
    applyStimulus(1'b1, 4'd11, 5'd0, 5'd0, 5'd0, 26'h10);
    @(negedge clock);
    checkOutput("clr_pre_we", 64'(imemWe), 64'(1));
    applyStimulus(1'b1, 4'd6, 5'd0, 5'd1, 5'd0, 26'd5);
    clear = 1'b1;
    #1 checkOutput("clr_ready", 64'(reqReady), 64'(0));
    @(negedge clock);
    clear = 1'b0;
    reqValid = 1'b0;
    checkOutput("clr_we",    64'(imemWe),   64'(0));
    checkOutput("clr_addr",  64'(imemAddr), 64'(0));
    checkOutput("clr_count", 64'(count),    64'(0));
    @(negedge clock);
    checkOutput("clr_we2", 64'(imemWe), 64'(0));

    // Small address space fills after four writes and blocks further requests.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 4'd6, 5'd0, 5'd1, 5'd0, 26'(i));
      reqValidS = 1'b1;
      #1 checkOutput("fill_ready", 64'(reqReadyS), 64'(1));
      @(negedge clock);
      reqValidS = 1'b0;
      checkOutput("fill_we",    64'(imemWeS),    64'(1));
      checkOutput("fill_addr",  64'(imemAddrS),  64'(i));
      checkOutput("fill_wdata", 64'(imemWdataS), 64'(32'h20010000 | 32'(i)));
    end
    @(negedge clock);
    checkOutput("full_flag",  64'(fullS),   64'(1));
    checkOutput("full_we",    64'(imemWeS), 64'(0));
    checkOutput("full_count", 64'(countS),  64'(4));
    reqValidS = 1'b1;
    #1 checkOutput("full_ready", 64'(reqReadyS), 64'(0));
    @(negedge clock);
    checkOutput("full_hold_we",    64'(imemWeS), 64'(0));
    checkOutput("full_hold_count", 64'(countS),  64'(4));
    clearS = 1'b1;
    @(negedge clock);
    clearS = 1'b0;
    checkOutput("full_clr_flag",  64'(fullS),     64'(0));
    checkOutput("full_clr_addr",  64'(imemAddrS), 64'(0));
    checkOutput("full_clr_count", 64'(countS),    64'(0));
    checkOutput("full_clr_we",    64'(imemWeS),   64'(0));
    #1 checkOutput("full_clr_ready", 64'(reqReadyS), 64'(1));
    reqValidS = 1'b0;

    // Randomized traffic against the behavioural model.
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    mPend = 1'b0; mFull = 1'b0; mErr = 1'b0; mAddr = 0; mCount = 0; mWord = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      clear     = ($urandom_range(0, 29) == 0);
      imemReady = ($urandom_range(0, 3) != 0);
      applyStimulus($urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)), 5'($urandom),
                    5'($urandom), 5'($urandom), 26'($urandom));
      #1;
      expReady = !clear && !mFull && (!mPend || imemReady);
      checkOutput("rnd_ready", 64'(reqReady),   64'(expReady));
      checkOutput("rnd_we",    64'(imemWe),     64'(mPend));
      checkOutput("rnd_addr",  64'(imemAddr),   64'(mAddr));
      checkOutput("rnd_count", 64'(count),      64'(mCount));
      checkOutput("rnd_full",  64'(full),       64'(mFull));
      checkOutput("rnd_err",   64'(errIllegal), 64'(mErr));
      if (mPend) checkOutput("rnd_wdata", 64'(imemWdata), 64'(mWord));
      refEncode(int'(reqOp), int'(reqRs), int'(reqRt), int'(reqRd), int'(reqImm), legal, word);
      xfer = reqValid && expReady;
      done = mPend && imemReady;
      if (clear) begin
        mPend = 1'b0; mFull = 1'b0; mErr = 1'b0; mAddr = 0; mCount = 0;
      end else begin
        mErr = xfer && !legal;
        if (done) begin
          mCount++;
          mPend = 1'b0;
          if (mAddr == (1 << AW) - 1) mFull = 1'b1;
          else mAddr++;
        end
        if (xfer && legal && !mFull) begin
          mPend = 1'b1;
          mWord = word;
        end
      end
      @(negedge clock);
    end

    // Reset in mid-cycle discards a pending word immediately.
    clear = 1'b0;
    imemReady = 1'b1;
    reqValid = 1'b0;
    @(negedge clock);
    applyStimulus(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 26'd0);
    imemReady = 1'b0;
    @(negedge clock);
    reqValid = 1'b0;
    checkOutput("arst_pre_we", 64'(imemWe), 64'(1));
    #2 reset = 1'b1;
    #1;
    checkOutput("arst_we",    64'(imemWe),   64'(0));
    checkOutput("arst_addr",  64'(imemAddr), 64'(0));
    checkOutput("arst_count", 64'(count),    64'(0));
    @(negedge clock);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
